// File: rtl/mac_accumulator_pkg.sv
// mac_accumulator_pkg: shared FSM encoding and width defaults for the MAC accumulator
package mac_accumulator_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ACCUM = 2'b01,
    DONE  = 2'b10
  } state_e;
  localparam int ACC_W_DEF = 40;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/mac_accumulator_sat_add.sv
// sat_add: ACC_W-bit signed add of a sign-extended 32-bit product, clamped on overflow
module sat_add
  import mac_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF
) (
  input  logic [31:0]      a,
  input  logic [ACC_W-1:0] b,
  output logic [ACC_W-1:0] sum,
  output logic             ovf
);
  logic [ACC_W:0] full;
  always_comb begin
    full = {b[ACC_W-1], b} + {{(ACC_W-31){a[31]}}, a};
    ovf  = full[ACC_W] ^ full[ACC_W-1];
    sum  = ovf ? {full[ACC_W], {(ACC_W-1){~full[ACC_W]}}} : full[ACC_W-1:0];
  end
endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: counted run of signed products into a saturating accumulator with result handshake
module mac_accumulator
  import mac_accumulator_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] length,
  input  logic             abort,
  input  logic [31:0]      prod,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [ACC_W-1:0] res,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy,
  output logic             ovf
);
  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d, sum_ovf;

  sat_add #(.ACC_W(ACC_W)) u_add (.a(prod), .b(acc_q), .sum(sum), .ovf(sum_ovf));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: if (start && !abort) begin
        acc_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = length;
        state_d = (length != '0) ? ACCUM : DONE;
      end
      ACCUM: if (abort) state_d = IDLE;
      else if (prod_valid) begin
        acc_d   = sum;
        ovf_d   = ovf_q | sum_ovf;
        cnt_d   = cnt_q - CNT_W'(1);
        state_d = (cnt_q == CNT_W'(1)) ? DONE : ACCUM;
      end
      DONE: state_d = (abort || res_ready) ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  assign prod_ready = state_q == ACCUM;
  assign res_valid  = state_q == DONE;
  assign busy       = state_q != IDLE;
  assign res        = acc_q;
  assign ovf        = ovf_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: drives a 40-bit and a 33-bit accumulator in lockstep against a saturating-sum model
module tb_mac_accumulator;
  logic clk = 0, rst = 1, start = 0, abort = 0, prod_valid = 0, res_ready = 0;
  logic [7:0] length = 0;
  logic [31:0] prod = 0;
  logic prod_ready_a, res_valid_a, busy_a, ovf_a;
  logic prod_ready_b, res_valid_b, busy_b, ovf_b;
  logic [39:0] res_a;
  logic [32:0] res_b;
  longint r40, r33;
  int errs = 0, checks = 0;
  logic signed [31:0] pq[$];

  assign r40 = longint'($signed(res_a));
  assign r33 = longint'($signed(res_b));

  always #5 clk = ~clk;

  mac_accumulator #(.ACC_W(40), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .length(length), .abort(abort),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready_a),
    .res(res_a), .res_valid(res_valid_a), .res_ready(res_ready),
    .busy(busy_a), .ovf(ovf_a)
  );

  mac_accumulator #(.ACC_W(33), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start), .length(length), .abort(abort),
    .prod(prod), .prod_valid(prod_valid), .prod_ready(prod_ready_b),
    .res(res_b), .res_valid(res_valid_b), .res_ready(res_ready),
    .busy(busy_b), .ovf(ovf_b)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic upd(inout longint e, inout logic o, input longint p, input int w);
    longint mx, mn, s;
    mx = (longint'(1) <<< (w - 1)) - 1;
    mn = -mx - 1;
    s  = e + p;
    o  = o | (s > mx) | (s < mn);
    e  = (s > mx) ? mx : (s < mn) ? mn : s;
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_busy_a"}, longint'(busy_a), 0);
    chk({tag, "_busy_b"}, longint'(busy_b), 0);
    chk({tag, "_rv_a"}, longint'(res_valid_a), 0);
    chk({tag, "_rdy_b"}, longint'(prod_ready_b), 0);
  endtask

  task automatic run(input int len, input int gap, input int rdly);
    longint e40 = 0, e33 = 0;
    logic o40 = 0, o33 = 0;
    int g;
    start = 1;
    length = len[7:0];
    @(negedge clk);
    start = 0;
    chk("clr_res40", r40, 0);
    chk("clr_ovf33", longint'(ovf_b), 0);
    chk("run_busy", longint'(busy_a), 1);
    for (int i = 0; i < len; i++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
      for (int k = 0; k <= g; k++) begin
        chk("acc_rdy_a", longint'(prod_ready_a), 1);
        chk("acc_rv_b", longint'(res_valid_b), 0);
        prod_valid = (k == g);
        prod = (k == g) ? pq[i] : $urandom;
        start = (k < g);
        length = 8'($urandom);
        @(negedge clk);
      end
      prod_valid = 0;
      start = 0;
      upd(e40, o40, longint'(pq[i]), 40);
      upd(e33, o33, longint'(pq[i]), 33);
    end
    chk("done_rv_a", longint'(res_valid_a), 1);
    chk("done_rv_b", longint'(res_valid_b), 1);
    chk("done_rdy_a", longint'(prod_ready_a), 0);
    chk("res40", r40, e40);
    chk("res33", r33, e33);
    chk("ovf40", longint'(ovf_a), longint'(o40));
    chk("ovf33", longint'(ovf_b), longint'(o33));
    for (int k = 0; k < rdly; k++) begin
      start = 1;
      @(negedge clk);
      chk("hold_rv", longint'(res_valid_a), 1);
      chk("hold_res40", r40, e40);
      chk("hold_res33", r33, e33);
    end
    start = 0;
    res_ready = 1;
    @(negedge clk);
    res_ready = 0;
    idle_chk("ret");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_res40", r40, 0);
    chk("rst_ovf_a", longint'(ovf_a), 0);
    idle_chk("rst");
    rst = 0;

    pq = '{32'sd100, -32'sd50, 32'sd7};
    run(3, 0, 0);
    chk("req035", r40, 57);

    pq = '{-32'sd1073709056, -32'sd1073709056, -32'sd1073709056, -32'sd1073709056};
    run(4, 2, 1);
    chk("req036_a", r40, -64'sd4294836224);
    chk("req036_b", r33, -64'sd4294836224);

    pq = '{32'sh7fffffff, 32'sh7fffffff, 32'sh7fffffff};
    run(3, 0, 0);
    chk("req037_res", r33, 64'sd4294967295);
    chk("req037_ovf", longint'(ovf_b), 1);

    run(0, 0, 5);
    chk("req038", r40, 0);

    start = 1;
    length = 5;
    @(negedge clk);
    start = 0;
    prod_valid = 1;
    prod = 32'd1234;
    @(negedge clk);
    prod = -32'sd99;
    abort = 1;
    @(negedge clk);
    prod_valid = 0;
    abort = 0;
    idle_chk("abort");
    chk("abort_res40", r40, 1234);
    chk("abort_res33", r33, 1234);
    repeat (3) begin
      @(negedge clk);
      chk("abort_norv", longint'(res_valid_b), 0);
    end
    start = 1;
    abort = 1;
    length = 3;
    @(negedge clk);
    start = 0;
    abort = 0;
    idle_chk("abort_idle");
    chk("abort_idle_res", r40, 1234);
    start = 1;
    length = 0;
    @(negedge clk);
    start = 0;
    chk("done_pre_abort", longint'(res_valid_a), 1);
    abort = 1;
    res_ready = 1;
    @(negedge clk);
    abort = 0;
    res_ready = 0;
    idle_chk("abort_done");

    start = 1;
    length = 4;
    @(negedge clk);
    start = 0;
    prod_valid = 1;
    prod = 32'd1000;
    @(negedge clk);
    prod = 32'd2000;
    @(negedge clk);
    rst = 1;
    prod = 32'd5;
    @(negedge clk);
    rst = 0;
    prod_valid = 0;
    idle_chk("midrst");
    chk("midrst_res40", r40, 0);
    chk("midrst_ovf", longint'(ovf_a), 0);
    pq = '{-32'sd1};
    run(1, 0, 0);
    chk("req040", r40, -1);

    repeat (14) begin
      int len;
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
      pq.delete();
      for (int i = 0; i < len; i++)
        pq.push_back(($urandom_range(0, 2) == 0) ? ($urandom_range(0, 1) ? 32'sh7fffffff : 32'sh80000000) : $urandom);
      run(len, -1, int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
